pixel_dispatcher: RTL and testbench
===================================

Name: pixel_dispatcher

Overview:
- Frame-level scheduler for the ray-tracing core array.
- Hands pixel coordinates (x, y) to up to 4 ray-tracing cores in strict round-robin raster order. This is the same order in which the downstream pixel buffer drains them.
- Counts pixels drained to the output stream. Generates start-of-frame / end-of-line sideband for the stream packer and a frame-done pulse for the host.
- Sits between the host control registers, the core array (job side) and the pixel buffer (completion side).

Parameters:
- COORD_W, 12, width of frame_width, frame_height, job_x, job_y and the internal coordinate counters.
- NUM_CORES, 4, physical core count. Fixed at 4; the round-robin pointer is 2 bits.

Ports:
- aclk  input  1  clock.
- aresetn  input  1  reset, asynchronous, active-low.
- start  input  1  single-cycle frame start request.
- frame_width  input  COORD_W  pixels per line; sampled on accepted start.
- frame_height  input  COORD_W  lines per frame; sampled on accepted start.
- no_of_extra_cores  input  3  active cores minus 1; sampled on accepted start.
- core_ready  input  4  core i can accept a job (driven by the pixel buffer's compute_ready_i).
- job_valid  output  4  one-hot; job_valid[i] offers the current job to core i.
- job_x  output  COORD_W  x coordinate of the offered job.
- job_y  output  COORD_W  y coordinate of the offered job.
- pixel_accept  input  1  one pixel written to the stream this cycle (out_valid and in_stream_ready).
- out_sof  output  1  the next pixel drained is (0,0) of the frame.
- out_eol  output  1  the next pixel drained is the last column of its line.
- busy  output  1  frame in progress.
- frame_done  output  1  one-cycle pulse after the last pixel has drained.

Behaviour:
- Reset values: all outputs are 0. State is IDLE, all counters 0, pointer 0.
- Configuration latched on accepted start:
  - W = frame_width, H = frame_height.
  - N = min(no_of_extra_cores, 3) + 1. Values 4..7 clamp to N = 4.
- States: IDLE, DISPATCH, DRAIN, DONE.
- IDLE:
  - busy = 0; pixel_accept is ignored.
  - start with W != 0 and H != 0: latch configuration; clear issue coordinates, drain coordinates, pointer and outstanding count; go to DISPATCH. busy = 1 from the next cycle.
  - start with W == 0 or H == 0: go to DONE, with no jobs issued.
- DISPATCH:
  - job_valid[ptr] = 1 only when outstanding < N; job_x / job_y = issue coordinates.
  - Handshake completes when job_valid[ptr] and core_ready[ptr] are both high.
  - On handshake:
    - x increments; when x = W-1, x goes to 0 and y increments.
    - ptr = (ptr+1) mod N.
    - outstanding increments.
  - Handshake of pixel (W-1, H-1) goes to DRAIN.
  - job_x, job_y and job_valid are registered and update the cycle after the handshake. No combinational path from core_ready to job_valid.
- Completion tracking (DISPATCH and DRAIN):
  - pixel_accept decrements outstanding and advances the drain coordinates in raster order.
  - A handshake and a pixel_accept in the same cycle leave outstanding unchanged.
  - pixel_accept while outstanding = 0 is ignored.
- Sideband (registered decode of the drain counters, valid only while busy):
  - out_sof = busy and drain (x, y) = (0, 0).
  - out_eol = busy and drain_x = W-1.
- DRAIN: the accept of drained pixel (W-1, H-1) goes to DONE.
- DONE: frame_done = 1 for exactly one cycle, busy = 0, then IDLE.
- start outside IDLE is ignored; no queuing.
- Input changes mid-frame: changes to frame_width, frame_height and no_of_extra_cores have no effect.
- aresetn asserted mid-frame: immediate return to reset values; no frame_done is produced.

Test Plan:
- W=4, H=2, extra=3, core_ready=4'hF, no accepts -> job_valid sequence 0001, 0010, 0100, 1000 with (x,y) = (0,0), (1,0), (2,0), (3,0); then job_valid = 0 (outstanding = 4). Eight accepts total -> remaining jobs (0,1)..(3,1) issued; frame_done pulses once, the cycle after the 8th accept is registered.
- W=3, H=1, extra=1, immediate accepts -> cores used 0, 1, 0; job_valid[3:2] never asserted.
- extra=7, W=5, H=1 -> N clamps to 4; core order 0, 1, 2, 3, 0.
- start with W=0, H=7 -> busy stays 0, no job_valid, frame_done pulses once.
- W=3, H=2 -> out_sof high only before the 1st accept; out_eol high before accepts 3 and 6. A start pulse mid-frame is ignored, and its new width does not change eol timing.
- Mid-frame aresetn low for 1 cycle after 2 jobs -> all outputs 0, no frame_done. A new start then begins again at (0,0) on core 0.

Source files
------------

// File: rtl/pixel_dispatcher_if.sv
// Job/completion bus between the pixel dispatcher, the core array and the pixel buffer.
interface pixel_dispatcher_if #(
    parameter int unsigned COORD_W   = 12,
    parameter int unsigned NUM_CORES = 4
);
    logic [NUM_CORES-1:0] core_ready;
    logic [NUM_CORES-1:0] job_valid;
    logic [COORD_W-1:0]   job_x;
    logic [COORD_W-1:0]   job_y;
    logic                 pixel_accept;
    logic                 out_sof;
    logic                 out_eol;

    modport master (
        input  core_ready, pixel_accept,
        output job_valid, job_x, job_y, out_sof, out_eol
    );

    modport slave (
        output core_ready, pixel_accept,
        input  job_valid, job_x, job_y, out_sof, out_eol
    );
endinterface

// File: rtl/pixel_dispatcher.sv
// Frame scheduler: issues raster-order pixel jobs round-robin to up to 4 cores,
// tracks drained pixels and produces sof/eol sideband and a frame-done pulse.
module pixel_dispatcher #(
    parameter int unsigned COORD_W   = 12,
    parameter int unsigned NUM_CORES = 4
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               start,
    input  logic [COORD_W-1:0] frame_width,
    input  logic [COORD_W-1:0] frame_height,
    input  logic [2:0]         no_of_extra_cores,
    pixel_dispatcher_if.master bus,
    output logic               busy,
    output logic               frame_done
);
    typedef enum logic [1:0] {ST_IDLE, ST_DISPATCH, ST_DRAIN, ST_DONE} state_t;

    state_t               state_q, state_d;
    logic [COORD_W-1:0]   cfg_w_q, cfg_w_d, cfg_h_q, cfg_h_d;
    logic [1:0]           cfg_nm1_q, cfg_nm1_d;
    logic [COORD_W-1:0]   ix_q, ix_d, iy_q, iy_d;
    logic [COORD_W-1:0]   dx_q, dx_d, dy_q, dy_d;
    logic [1:0]           ptr_q, ptr_d;
    logic [2:0]           outst_q, outst_d;
    logic [NUM_CORES-1:0] job_valid_q, job_valid_d;
    logic                 sof_q, sof_d, eol_q, eol_d;
    logic                 hs, acc, busy_d;

    // State, configuration, counters and registered outputs.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            cfg_w_q     <= '0;
            cfg_h_q     <= '0;
            cfg_nm1_q   <= '0;
            ix_q        <= '0;
            iy_q        <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            ptr_q       <= '0;
            outst_q     <= '0;
            job_valid_q <= '0;
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_w_q     <= cfg_w_d;
            cfg_h_q     <= cfg_h_d;
            cfg_nm1_q   <= cfg_nm1_d;
            ix_q        <= ix_d;
            iy_q        <= iy_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            ptr_q       <= ptr_d;
            outst_q     <= outst_d;
            job_valid_q <= job_valid_d;
            sof_q       <= sof_d;
            eol_q       <= eol_d;
        end
    end

    // Next-state logic; job_valid and sideband are decoded from next-state values
    // so the outputs are registered yet track the counters without a cycle of lag.
    always_comb begin
        state_d   = state_q;
        cfg_w_d   = cfg_w_q;
        cfg_h_d   = cfg_h_q;
        cfg_nm1_d = cfg_nm1_q;
        ix_d      = ix_q;
        iy_d      = iy_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        ptr_d     = ptr_q;
        outst_d   = outst_q;
        hs        = 1'b0;
        acc       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (frame_width != '0 && frame_height != '0) begin
                        cfg_w_d   = frame_width;
                        cfg_h_d   = frame_height;
                        cfg_nm1_d = (no_of_extra_cores > 3'd3) ? 2'd3 : no_of_extra_cores[1:0];
                        ix_d      = '0;
                        iy_d      = '0;
                        dx_d      = '0;
                        dy_d      = '0;
                        ptr_d     = '0;
                        outst_d   = '0;
                        state_d   = ST_DISPATCH;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DISPATCH, ST_DRAIN: begin
                hs  = (state_q == ST_DISPATCH) && (|(job_valid_q & bus.core_ready));
                acc = bus.pixel_accept && (outst_q != '0);
                if (hs) begin
                    if (ix_q == cfg_w_q - COORD_W'(1)) begin
                        ix_d = '0;
                        iy_d = iy_q + COORD_W'(1);
                        if (iy_q == cfg_h_q - COORD_W'(1)) begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        ix_d = ix_q + COORD_W'(1);
                    end
                    ptr_d = (ptr_q == cfg_nm1_q) ? 2'd0 : ptr_q + 2'd1;
                end
                if (acc) begin
                    if (dx_q == cfg_w_q - COORD_W'(1)) begin
                        dx_d = '0;
                        dy_d = dy_q + COORD_W'(1);
                        if (dy_q == cfg_h_q - COORD_W'(1)) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        dx_d = dx_q + COORD_W'(1);
                    end
                end
                outst_d = outst_q + {2'b00, hs} - {2'b00, acc};
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        job_valid_d = '0;
        if (state_d == ST_DISPATCH && outst_d < ({1'b0, cfg_nm1_d} + 3'd1)) begin
            job_valid_d[ptr_d] = 1'b1;
        end
        busy_d = (state_d == ST_DISPATCH) || (state_d == ST_DRAIN);
        sof_d  = busy_d && (dx_d == '0) && (dy_d == '0);
        eol_d  = busy_d && (dx_d == cfg_w_d - COORD_W'(1));
    end

    assign bus.job_valid = job_valid_q;
    assign bus.job_x     = ix_q;
    assign bus.job_y     = iy_q;
    assign bus.out_sof   = sof_q;
    assign bus.out_eol   = eol_q;
    assign busy          = (state_q == ST_DISPATCH) || (state_q == ST_DRAIN);
    assign frame_done    = (state_q == ST_DONE);
endmodule

// File: tb/tb_pixel_dispatcher.sv
// Directed bench for pixel_dispatcher with hand-computed expectations.
module tb_pixel_dispatcher;
    localparam int unsigned CW = 12;

    logic          aclk;
    logic          aresetn;
    logic          start;
    logic [CW-1:0] frame_width;
    logic [CW-1:0] frame_height;
    logic [2:0]    no_of_extra_cores;
    logic          busy;
    logic          frame_done;

    int unsigned n_checks;
    int unsigned n_pass;

    pixel_dispatcher_if #(.COORD_W(CW), .NUM_CORES(4)) bus ();

    pixel_dispatcher #(.COORD_W(CW), .NUM_CORES(4)) dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .start             (start),
        .frame_width       (frame_width),
        .frame_height      (frame_height),
        .no_of_extra_cores (no_of_extra_cores),
        .bus               (bus),
        .busy              (busy),
        .frame_done        (frame_done)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_start(input int w, input int h, input int e);
        frame_width       = CW'(w);
        frame_height      = CW'(h);
        no_of_extra_cores = 3'(e);
        start             = 1'b1;
        step();
        start             = 1'b0;
    endtask

    // Clamp check: no accepts until 4 jobs are out; then drain a W=5,H=1 frame.
    task automatic run_clamp(input int e);
        logic [3:0] exp_jv;
        bus.core_ready   = 4'hF;
        bus.pixel_accept = 1'b0;
        do_start(5, 1, e);
        for (int i = 0; i < 4; i++) begin
            exp_jv = 4'b0001 << i;
            check($sformatf("clamp%0d_jv%0d", e, i), {28'd0, bus.job_valid}, {28'd0, exp_jv});
            step();
        end
        check($sformatf("clamp%0d_full", e), {28'd0, bus.job_valid}, 32'd0);
        bus.pixel_accept = 1'b1;
        step();
        check($sformatf("clamp%0d_wrap_jv", e), {28'd0, bus.job_valid}, 32'h1);
        check($sformatf("clamp%0d_wrap_x", e), {20'd0, bus.job_x}, 32'd4);
        for (int i = 0; i < 4; i++) step();
        check($sformatf("clamp%0d_done", e), {31'd0, frame_done}, 32'd1);
        bus.pixel_accept = 1'b0;
        step();
        check($sformatf("clamp%0d_done_end", e), {31'd0, frame_done}, 32'd0);
    endtask

    initial begin
        logic [3:0] jv_tab [8];
        logic [3:0] hi_seen;
        int         done_seen;

        n_checks          = 0;
        n_pass            = 0;
        aresetn           = 1'b0;
        start             = 1'b0;
        frame_width       = '0;
        frame_height      = '0;
        no_of_extra_cores = '0;
        bus.core_ready    = '0;
        bus.pixel_accept  = 1'b0;

        // Reset state
        step();
        check("rst_jv",   {28'd0, bus.job_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, frame_done}, 32'd0);
        check("rst_sof",  {31'd0, bus.out_sof}, 32'd0);
        aresetn = 1'b1;
        step();

        // Test 1: W=4 H=2 N=4, outstanding limit then eight accepts
        bus.core_ready = 4'hF;
        do_start(4, 2, 3);
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_sof",  {31'd0, bus.out_sof}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_jv%0d", i), {28'd0, bus.job_valid}, 32'(4'b0001 << i));
            check($sformatf("t1_x%0d", i),  {20'd0, bus.job_x}, 32'(i));
            check($sformatf("t1_y%0d", i),  {20'd0, bus.job_y}, 32'd0);
            step();
        end
        check("t1_full", {28'd0, bus.job_valid}, 32'd0);
        step();
        check("t1_full2", {28'd0, bus.job_valid}, 32'd0);
        jv_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        bus.pixel_accept = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("t1_acc_jv%0d", k), {28'd0, bus.job_valid}, {28'd0, jv_tab[k]});
            if (k < 4) begin
                check($sformatf("t1_acc_x%0d", k), {20'd0, bus.job_x}, 32'(k));
                check($sformatf("t1_acc_y%0d", k), {20'd0, bus.job_y}, 32'd1);
            end
            check($sformatf("t1_done%0d", k), {31'd0, frame_done}, (k == 7) ? 32'd1 : 32'd0);
        end
        bus.pixel_accept = 1'b0;
        step();
        check("t1_done_end", {31'd0, frame_done}, 32'd0);
        check("t1_idle",     {31'd0, busy}, 32'd0);

        // Test 2: W=3 H=1 N=2, accept held high
        hi_seen          = '0;
        bus.pixel_accept = 1'b1;
        do_start(3, 1, 1);
        jv_tab = '{4'b0001, 4'b0010, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        for (int k = 0; k < 4; k++) begin
            hi_seen |= bus.job_valid;
            check($sformatf("t2_jv%0d", k), {28'd0, bus.job_valid}, {28'd0, jv_tab[k]});
            step();
        end
        check("t2_done", {31'd0, frame_done}, 32'd1);
        check("t2_hi_cores", {28'd0, hi_seen & 4'b1100}, 32'd0);
        bus.pixel_accept = 1'b0;
        step();

        // Test 3: N clamps to 4 for extra=7 and extra=4
        run_clamp(7);
        run_clamp(4);

        // Test 4: zero-size frame
        do_start(0, 7, 3);
        check("t4_busy", {31'd0, busy}, 32'd0);
        check("t4_jv",   {28'd0, bus.job_valid}, 32'd0);
        check("t4_done", {31'd0, frame_done}, 32'd1);
        step();
        check("t4_done_end", {31'd0, frame_done}, 32'd0);

        // Test 5: sideband for W=3 H=2, ignored mid-frame start
        do_start(3, 2, 3);
        for (int i = 0; i < 4; i++) step();
        do_start(5, 9, 0);
        check("t5_busy", {31'd0, busy}, 32'd1);
        for (int k = 1; k <= 6; k++) begin
            check($sformatf("t5_sof%0d", k), {31'd0, bus.out_sof}, (k == 1) ? 32'd1 : 32'd0);
            check($sformatf("t5_eol%0d", k), {31'd0, bus.out_eol}, (k == 3 || k == 6) ? 32'd1 : 32'd0);
            bus.pixel_accept = 1'b1;
            step();
            bus.pixel_accept = 1'b0;
            if (k == 6) check("t5_done", {31'd0, frame_done}, 32'd1);
            step();
        end
        check("t5_idle", {31'd0, busy}, 32'd0);

        // Test 6: reset mid-frame, then a fresh frame
        do_start(4, 2, 3);
        step();
        step();
        aresetn = 1'b0;
        #1;
        check("t6_jv",   {28'd0, bus.job_valid}, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_x",    {20'd0, bus.job_x}, 32'd0);
        check("t6_sof",  {31'd0, bus.out_sof}, 32'd0);
        step();
        aresetn   = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (frame_done) done_seen++;
            step();
        end
        check("t6_no_done", 32'(done_seen), 32'd0);
        do_start(2, 1, 0);
        check("t6_new_jv", {28'd0, bus.job_valid}, 32'd1);
        check("t6_new_x",  {20'd0, bus.job_x}, 32'd0);
        check("t6_new_y",  {20'd0, bus.job_y}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
